// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: function codes, FSM state type and iterative-op encoding
// shared by alu_seq and alu_seq_iter.
package alu_seq_pkg;

    // Single-cycle ALU function set (values fixed for compatibility)
    localparam logic [4:0] FC_ADD   = 5'd0;
    localparam logic [4:0] FC_SUB   = 5'd1;
    localparam logic [4:0] FC_ID    = 5'd2;
    localparam logic [4:0] FC_NOT   = 5'd3;
    localparam logic [4:0] FC_AND   = 5'd4;
    localparam logic [4:0] FC_OR    = 5'd5;
    localparam logic [4:0] FC_NAND  = 5'd6;
    localparam logic [4:0] FC_NOR   = 5'd7;
    localparam logic [4:0] FC_XOR   = 5'd8;
    localparam logic [4:0] FC_XNOR  = 5'd9;
    localparam logic [4:0] FC_LLS   = 5'd10;
    localparam logic [4:0] FC_LRS   = 5'd11;
    localparam logic [4:0] FC_ALS   = 5'd12;
    localparam logic [4:0] FC_ARS   = 5'd13;
    localparam logic [4:0] FC_TCP   = 5'd14;
    localparam logic [4:0] FC_ZERO  = 5'd15;

    // Iterative operations
    localparam logic [4:0] FC_MUL   = 5'd16;
    localparam logic [4:0] FC_LSHN  = 5'd17;
    localparam logic [4:0] FC_RSHN  = 5'd18;
    localparam logic [4:0] FC_ARSHN = 5'd19;

    localparam logic [4:0] FC_ITER_LO  = FC_MUL;
    localparam logic [4:0] FC_ITER_HI  = FC_ARSHN;
    localparam logic [4:0] FC_SHIFT_LO = FC_LSHN;
    localparam logic [4:0] FC_SHIFT_HI = FC_ARSHN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        IT_MUL   = 2'd0,
        IT_LSHN  = 2'd1,
        IT_RSHN  = 2'd2,
        IT_ARSHN = 2'd3
    } iter_op_e;

    function automatic iter_op_e to_iter_op(input logic [4:0] fc);
        case (fc)
            FC_MUL:   return IT_MUL;
            FC_RSHN:  return IT_RSHN;
            FC_ARSHN: return IT_ARSHN;
            default:  return IT_LSHN;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: multi-cycle engine for N-bit shifts (one bit per cycle) and
// unsigned shift-add multiply (DATA_WIDTH cycles). 'result'/'hi_nonzero' carry
// the value produced by the step taken in the cycle where 'done' is high, so
// the parent can register it on that same edge.
// Macro ALU_SEQ_MUL_EN: when undefined the multiplier registers are omitted.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  iter_op_e               op,
    input  logic [DATA_WIDTH-1:0]  a,
    input  logic [DATA_WIDTH-1:0]  b,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   hi_nonzero
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    iter_op_e              op_q, op_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_step;

`ifdef ALU_SEQ_MUL_EN
    logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [2*DATA_WIDTH-1:0] prod_q, prod_d, prod_step;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
`else
    logic unused_b;
    assign unused_b = ^b;
`endif

    // One shift step of the accumulator
    always_comb begin
        acc_step = acc_q;
        case (op_q)
            IT_LSHN:  acc_step = acc_q << 1;
            IT_RSHN:  acc_step = acc_q >> 1;
            IT_ARSHN: acc_step = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
            default:  acc_step = acc_q;
        endcase
    end

    // Load on start, otherwise step while the down-counter is non-zero
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        acc_d = acc_q;
`ifdef ALU_SEQ_MUL_EN
        prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        mplier_d  = mplier_q;
`endif
        if (start) begin
            op_d  = op;
            acc_d = a;
            cnt_d = (op == IT_MUL) ? CNT_W'(DATA_WIDTH) : CNT_W'(shamt);
`ifdef ALU_SEQ_MUL_EN
            mcand_d  = {{DATA_WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
`endif
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            acc_d = acc_step;
`ifdef ALU_SEQ_MUL_EN
            prod_d   = prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
`endif
        end
    end

    // Status and result of the final step
    always_comb begin
        busy = (cnt_q != '0);
        done = (cnt_q == CNT_W'(1));
`ifdef ALU_SEQ_MUL_EN
        result     = (op_q == IT_MUL) ? prod_step[DATA_WIDTH-1:0] : acc_step;
        hi_nonzero = (op_q == IT_MUL) && (prod_step[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
`else
        result     = acc_step;
        hi_nonzero = 1'b0;
`endif
    end

    // Engine registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            op_q  <= IT_LSHN;
            acc_q <= '0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
`endif
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            acc_q <= acc_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
`endif
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU. Single-cycle ops complete in one cycle;
// N-bit shifts and multiply run in alu_seq_iter. Result and flags are
// registered and held in DONE until the consumer takes them.
// Macro ALU_SEQ_MUL_EN: enables MUL (code 16); otherwise code 16 is illegal.
//
//   state   | meaning
//   IDLE    | ready to accept a request
//   BUSY    | iterative shift / multiply in progress
//   DONE    | C and flags valid, waiting for out_ready
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [4:0]            FuncCode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] C,
    output logic                  OverflowFlag,
    output logic                  ZeroFlag,
    output logic                  NegFlag,
    output logic                  IllegalOp
);

    localparam int MSB = DATA_WIDTH - 1;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  c_q, c_d;
    logic                   ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d, ill_q, ill_d;

    logic [DATA_WIDTH-1:0]  sum, diff, alu_res;
    logic                   alu_ovf;
    logic                   is_shift, is_mul, legal;
    logic [SHAMT_WIDTH-1:0] shamt;

    logic                   load, load_ovf, load_ill;
    logic [DATA_WIDTH-1:0]  load_c;

    logic                   iter_start, iter_busy, iter_done, iter_hi_nz;
    logic [DATA_WIDTH-1:0]  iter_result;

    assign sum   = A + B;
    assign diff  = A - B;
    assign shamt = B[SHAMT_WIDTH-1:0];

    // Request classification
    always_comb begin
        is_shift = (FuncCode >= FC_SHIFT_LO) && (FuncCode <= FC_SHIFT_HI);
`ifdef ALU_SEQ_MUL_EN
        is_mul = (FuncCode == FC_MUL);
`else
        is_mul = 1'b0;
`endif
        legal = (FuncCode <= FC_ZERO) || is_shift || is_mul;
    end

    // Single-cycle function set; zero-amount shifts fall to the default (C = A)
    always_comb begin
        alu_res = A;
        alu_ovf = 1'b0;
        case (FuncCode)
            FC_ADD: begin
                alu_res = sum;
                alu_ovf = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            FC_SUB: begin
                alu_res = diff;
                alu_ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            end
            FC_ID:   alu_res = A;
            FC_NOT:  alu_res = ~A;
            FC_AND:  alu_res = A & B;
            FC_OR:   alu_res = A | B;
            FC_NAND: alu_res = ~(A & B);
            FC_NOR:  alu_res = ~(A | B);
            FC_XOR:  alu_res = A ^ B;
            FC_XNOR: alu_res = ~(A ^ B);
            FC_LLS:  alu_res = A << 1;
            FC_LRS:  alu_res = A >> 1;
            FC_ALS:  alu_res = A << 1;
            FC_ARS:  alu_res = {A[MSB], A[MSB:1]};
            FC_TCP:  alu_res = '0 - A;
            FC_ZERO: alu_res = '0;
            default: alu_res = A;
        endcase
    end

    // Sequencer and result/flag load
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_c     = '0;
        load_ovf   = 1'b0;
        load_ill   = 1'b0;
        iter_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul || (is_shift && shamt != '0)) begin
                        iter_start = 1'b1;
                        state_d    = ST_BUSY;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_DONE;
                        if (!legal) begin
                            load_ill = 1'b1;
                        end else begin
                            load_c   = alu_res;
                            load_ovf = alu_ovf;
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    load     = 1'b1;
                    load_c   = iter_result;
                    load_ovf = iter_hi_nz;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        c_d    = load ? load_c : c_q;
        ovf_d  = load ? load_ovf : ovf_q;
        ill_d  = load ? load_ill : ill_q;
        zero_d = load ? (load_c == '0) : zero_q;
        neg_d  = load ? load_c[MSB] : neg_q;
    end

    alu_seq_iter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_iter (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (iter_start),
        .op         (to_iter_op(FuncCode)),
        .a          (A),
        .b          (B),
        .shamt      (shamt),
        .busy       (iter_busy),
        .done       (iter_done),
        .result     (iter_result),
        .hi_nonzero (iter_hi_nz)
    );

    logic unused_iter_busy;
    assign unused_iter_busy = iter_busy;

    // State, result and flag registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign C            = c_q;
    assign OverflowFlag = ovf_q;
    assign ZeroFlag     = zero_q;
    assign NegFlag      = neg_q;
    assign IllegalOp    = ill_q;

endmodule
